// File: rtl/im_loader.sv
// rtl/im_loader.sv - boot-time byte-stream loader that fills instruction memory and holds the CPU in reset
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid, in_data,  byte stream from the host/UART source; in_last marks the
//   in_last, in_ready   final byte of the image, in_ready accepts a byte
//   im_we, im_addr,     IM write port: one-cycle pulse per packed big-endian word
//   im_wdata
//   cpu_rst             held high until the final word is committed
//   words_loaded        number of words written to IM so far
//   done                image committed and CPU released
//   err                 image did not fit in IM above BASE_WORD (sticky)
module im_loader #(
    parameter int                ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] BASE_WORD = 14'h0C00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic [ADDR_W:0]   words_loaded,
    output logic              done,
    output logic              err
);

    // Number of IM words available from BASE_WORD up to the top of IM.
    localparam logic [ADDR_W:0] CAPACITY =
        (ADDR_W+1)'(1 << ADDR_W) - {1'b0, BASE_WORD};

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMMIT,
        S_RUN,
        S_ERR
    } state_t;

    state_t          state;
    logic [1:0]      bc;
    logic [31:0]     word_q;
    logic            accept;
    logic [ADDR_W:0] wl_eff;
    logic            full;
    logic [31:0]     packed_word;

    assign accept = in_valid && in_ready;

    // words_loaded only advances on the edge that ends the im_we pulse, so a
    // write still in flight must be counted when addressing the next word and
    // when deciding whether IM is already full.
    assign wl_eff = words_loaded + {{ADDR_W{1'b0}}, im_we};
    assign full   = (wl_eff == CAPACITY);

    // Merge the incoming byte into its lane. Lanes below the current one are
    // forced to zero, which gives the zero-fill of a short final word for free.
    always_comb begin
        packed_word = 32'h0;
        case (bc)
            2'd0:    packed_word = {in_data, 24'h0};
            2'd1:    packed_word = {word_q[31:24], in_data, 16'h0};
            2'd2:    packed_word = {word_q[31:16], in_data, 8'h0};
            default: packed_word = {word_q[31:8], in_data};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LOAD;
            bc           <= 2'd0;
            word_q       <= 32'h0;
            in_ready     <= 1'b1;
            im_we        <= 1'b0;
            im_addr      <= BASE_WORD;
            im_wdata     <= 32'h0;
            cpu_rst      <= 1'b1;
            words_loaded <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            im_we <= 1'b0;
            if (im_we) begin
                words_loaded <= words_loaded + 1'b1;
            end

            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (bc == 2'd0 && full) begin
                            // No room for another word: drop the byte and stop.
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            word_q <= packed_word;
                            if (in_last || bc == 2'd3) begin
                                im_we    <= 1'b1;
                                im_wdata <= packed_word;
                                im_addr  <= BASE_WORD + wl_eff[ADDR_W-1:0];
                                bc       <= 2'd0;
                            end else begin
                                bc <= bc + 2'd1;
                            end
                            if (in_last) begin
                                state    <= S_COMMIT;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end

                S_COMMIT: begin
                    // The final write lands on this edge; the CPU leaves
                    // reset only afterwards.
                    state   <= S_RUN;
                    cpu_rst <= 1'b0;
                    done    <= 1'b1;
                end

                S_RUN: begin
                end

                S_ERR: begin
                end

                default: begin
                    state    <= S_ERR;
                    in_ready <= 1'b0;
                    err      <= 1'b1;
                end
            endcase
        end
    end

endmodule
